// File: rtl/mac_ctrl_pkg.sv
// Shared state encoding and array instruction codes for the MAC sequencing controller.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    KGAP,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable up-counter with a terminal-count flag; used for phase timing and valid counting.
module mac_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (inc)
      count <= count + W'(1);
  end

  assign tc = (count == term);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the MAC array: loads COL kernel words, waits for them to settle,
// streams alen activation vectors, then waits for the array to drain its results.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int COL     = 8,
  parameter int ADDR_BW = 11,
  parameter int LEN_BW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode_in,
  input  logic [ADDR_BW-1:0] kbase,
  input  logic [ADDR_BW-1:0] abase,
  input  logic [LEN_BW-1:0]  alen,
  input  logic               valid_last,
  output logic               mem_en,
  output logic [ADDR_BW-1:0] mem_addr,
  output logic [1:0]         inst_w,
  output logic               mode,
  output logic               busy,
  output logic               done
);

  // Phase counter must hold both COL (gap length) and alen-1 (exec length).
  localparam int PCNT_BW = (LEN_BW > $clog2(COL + 1)) ? LEN_BW : $clog2(COL + 1);

  state_t              state, state_next;
  logic [ADDR_BW-1:0]  kbase_r, abase_r;
  logic [LEN_BW-1:0]   alen_r;
  logic [1:0]          inst_issue;
  logic                accept;

  logic [PCNT_BW-1:0]  pcnt, pterm;
  logic                ptc, pload, pinc;

  logic [LEN_BW-1:0]   vcnt;
  logic                vtc, vload, vinc, vreached, in_collect;

  assign accept = (state == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      kbase_r <= '0;
      abase_r <= '0;
      alen_r  <= '0;
      mode    <= 1'b0;
      inst_w  <= INST_IDLE;
    end else begin
      state  <= state_next;
      inst_w <= inst_issue;
      if (accept) begin
        kbase_r <= kbase;
        abase_r <= abase;
        alen_r  <= alen;
        mode    <= mode_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    pterm      = '0;
    pinc       = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    inst_issue = INST_IDLE;
    case (state)
      IDLE: if (accept) state_next = KLOAD;
      KLOAD: begin
        pterm      = PCNT_BW'(COL - 1);
        pinc       = 1'b1;
        mem_en     = 1'b1;
        mem_addr   = kbase_r + ADDR_BW'(pcnt);
        inst_issue = INST_KLOAD;
        if (ptc) state_next = KGAP;
      end
      KGAP: begin
        pterm = PCNT_BW'(COL);
        pinc  = 1'b1;
        if (ptc) state_next = (alen_r == '0) ? DONE : EXEC;
      end
      EXEC: begin
        pterm      = PCNT_BW'(alen_r) - PCNT_BW'(1);
        pinc       = 1'b1;
        mem_en     = 1'b1;
        mem_addr   = abase_r + ADDR_BW'(pcnt);
        inst_issue = INST_EXEC;
        if (ptc) state_next = DRAIN;
      end
      DRAIN:   if (vreached) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // Phase counter restarts from zero on every state change.
  assign pload = (state_next != state);

  mac_seq_cnt #(.W(PCNT_BW)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (pload),
    .load_val ('0),
    .inc      (pinc),
    .term     (pterm),
    .count    (pcnt),
    .tc       (ptc)
  );

  // Valid counter saturates at alen so surplus pulses cannot skip the exit condition.
  assign in_collect = (state == EXEC) || (state == DRAIN);
  assign vload      = !in_collect;
  assign vinc       = in_collect && valid_last && !vtc;
  assign vreached   = vtc || (valid_last && ((vcnt + LEN_BW'(1)) == alen_r));

  mac_seq_cnt #(.W(LEN_BW)) u_valid_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (vload),
    .load_val ('0),
    .inc      (vinc),
    .term     (alen_r),
    .count    (vcnt),
    .tc       (vtc)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed vector table, hand-written corner
// sequences and randomized passes scored against a cycle-index reference model.
module tb_mac_seq_ctrl;

  localparam int COL     = 8;
  localparam int ADDR_BW = 11;
  localparam int LEN_BW  = 8;
  localparam int E0      = 2 * COL + 2;
  localparam int MAXC    = 256;

  typedef struct packed {
    logic               en;
    logic [ADDR_BW-1:0] addr;
    logic [1:0]         inst;
    logic               busy;
    logic               done;
  } obs_t;

  typedef struct {
    int kb; int ab; int al; bit md; int lat;
    int exp_done; int exp_fk; int exp_lk; int exp_fx; int exp_lx;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset, start, abort, mode_in, valid_last;
  logic [ADDR_BW-1:0] kbase, abase;
  logic [LEN_BW-1:0]  alen;
  logic               mem_en;
  logic [ADDR_BW-1:0] mem_addr;
  logic [1:0]         inst_w;
  logic               mode, busy, done;

  int         checks = 0;
  int         failures = 0;
  int         m_kbase, m_abase, m_alen, m_abort, m_done;
  int         pass_id = 0;
  logic [1:0] carry_inst = 2'b00;
  bit         vl_sched [MAXC];
  vec_t       vecs [5];

  mac_seq_ctrl #(.COL(COL), .ADDR_BW(ADDR_BW), .LEN_BW(LEN_BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode_in    (mode_in),
    .kbase      (kbase),
    .abase      (abase),
    .alen       (alen),
    .valid_last (valid_last),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .inst_w     (inst_w),
    .mode       (mode),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the cycle start is driven; outputs of cycle c follow the edge ending cycle c-1.
  function automatic obs_t raw_at(int c);
    obs_t o = '0;
    if (c >= 1 && c <= m_done) begin
      o.busy = 1'b1;
      o.done = (c == m_done);
      if (c <= COL) begin
        o.en   = 1'b1;
        o.addr = ADDR_BW'(m_kbase + c - 1);
        o.inst = 2'b01;
      end else if (c >= E0 && c < E0 + m_alen) begin
        o.en   = 1'b1;
        o.addr = ADDR_BW'(m_abase + c - E0);
        o.inst = 2'b10;
      end
    end
    return o;
  endfunction

  function automatic obs_t exp_at(int c);
    obs_t       o = raw_at(c);
    obs_t       p = raw_at(c - 1);
    logic [1:0] prev;
    prev = (c == 0) ? carry_inst : p.inst;
    if (m_abort >= 0 && c > m_abort) begin
      o = '0;
      if (c > m_abort + 1) prev = 2'b00;
    end
    o.inst = prev;
    return o;
  endfunction

  // Done follows the alen-th counted pulse, but never before one drain cycle.
  function automatic int model_done();
    int cnt = 0;
    if (m_alen == 0) return E0;
    for (int c = E0; c < MAXC; c++) begin
      if (vl_sched[c]) begin
        cnt++;
        if (cnt == m_alen) return (c + 1 > E0 + m_alen + 1) ? c + 1 : E0 + m_alen + 1;
      end
    end
    return MAXC;
  endfunction

  task automatic make_sched_table(input int al, input int lat);
    for (int c = 0; c < MAXC; c++) vl_sched[c] = 1'b0;
    for (int i = 0; i < al; i++) vl_sched[E0 + lat + i] = 1'b1;
  endtask

  task automatic make_sched_rand(input int al);
    int cur;
    for (int c = 0; c < MAXC; c++)
      vl_sched[c] = (c >= 1 && c < E0) ? ($urandom_range(0, 3) == 0) : 1'b0;
    cur = E0 - 1 + int'($urandom_range(0, 3));
    for (int i = 0; i < al; i++) begin
      cur = cur + 1 + int'($urandom_range(0, 2));
      vl_sched[cur] = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, got, req);
    end
  endtask

  task automatic applyStimulus(input int c, input int kb, input int ab, input int al, input bit md,
                               input int ab_cyc, input bit chaos, input int lim);
    if (c == 0) begin
      start   = 1'b1;
      kbase   = ADDR_BW'(kb);
      abase   = ADDR_BW'(ab);
      alen    = LEN_BW'(al);
      mode_in = md;
    end else begin
      start   = chaos && (c <= lim) && ($urandom_range(0, 3) == 0);
      kbase   = ADDR_BW'($urandom);
      abase   = ADDR_BW'($urandom);
      alen    = LEN_BW'($urandom);
      mode_in = 1'($urandom_range(0, 1));
    end
    abort      = (c == ab_cyc);
    valid_last = (c < MAXC) ? vl_sched[c] : 1'b0;
  endtask

  task automatic run_pass(input int kb, input int ab, input int al, input bit md, input int ab_cyc,
                          input bit chaos, output int o_done, output int o_nen, output int o_nk,
                          output int o_nx, output int o_fk, output int o_lk, output int o_fx,
                          output int o_lx);
    int   last, lim;
    obs_t got, req, at_abort;
    pass_id++;
    m_kbase = kb; m_abase = ab; m_alen = al; m_abort = ab_cyc;
    m_done  = model_done();
    last = (ab_cyc >= 0) ? ab_cyc : m_done + 2;
    lim  = (ab_cyc >= 0 && ab_cyc < m_done) ? ab_cyc : m_done;
    o_done = -1; o_nen = 0; o_nk = 0; o_nx = 0;
    o_fk = -1; o_lk = -1; o_fx = -1; o_lx = -1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      got = {mem_en, mem_addr, inst_w, busy, done};
      req = exp_at(c);
      checkOutput($sformatf("pass%0d_cyc%0d", pass_id, c),
                  {15'd0, got, req.busy ? mode : 1'b0}, {15'd0, req, req.busy ? md : 1'b0});
      if (done === 1'b1 && o_done < 0) o_done = c;
      if (mem_en === 1'b1) begin
        o_nen++;
        if (o_nen == 1)       o_fk = int'(mem_addr);
        if (o_nen == COL)     o_lk = int'(mem_addr);
        if (o_nen == COL + 1) o_fx = int'(mem_addr);
        o_lx = int'(mem_addr);
      end
      if (inst_w === 2'b01) o_nk++;
      if (inst_w === 2'b10) o_nx++;
      applyStimulus(c, kb, ab, al, md, ab_cyc, chaos, lim);
    end
    at_abort   = raw_at(ab_cyc);
    carry_inst = (ab_cyc >= 0) ? at_abort.inst : 2'b00;
  endtask

  initial begin
    int d_done, d_nen, d_nk, d_nx, d_fk, d_lk, d_fx, d_lx;
    int al, ab_cyc;
    bit md;

    vecs[0] = '{kb: 'h010, ab: 'h100, al: 4, md: 1'b0, lat: 2, exp_done: 24,
                exp_fk: 'h010, exp_lk: 'h017, exp_fx: 'h100, exp_lx: 'h103};
    vecs[1] = '{kb: 'h020, ab: 'h200, al: 0, md: 1'b1, lat: 0, exp_done: 18,
                exp_fk: 'h020, exp_lk: 'h027, exp_fx: -1, exp_lx: 'h027};
    vecs[2] = '{kb: 'h000, ab: 'h7FE, al: 4, md: 1'b1, lat: 2, exp_done: 24,
                exp_fk: 'h000, exp_lk: 'h007, exp_fx: 'h7FE, exp_lx: 'h001};
    vecs[3] = '{kb: 'h7FC, ab: 'h000, al: 1, md: 1'b0, lat: 0, exp_done: 20,
                exp_fk: 'h7FC, exp_lk: 'h003, exp_fx: 'h000, exp_lx: 'h000};
    vecs[4] = '{kb: 'h155, ab: 'h3F0, al: 3, md: 1'b1, lat: 5, exp_done: 26,
                exp_fk: 'h155, exp_lk: 'h15C, exp_fx: 'h3F0, exp_lx: 'h3F2};

    reset = 1'b0; start = 1'b1; abort = 1'b0; mode_in = 1'b1; valid_last = 1'b1;
    kbase = '1; abase = '1; alen = '1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {15'd0, mem_en, mem_addr, inst_w, busy, done, mode}, 32'd0);
    reset = 1'b1; start = 1'b0; valid_last = 1'b0; mode_in = 1'b0;

    // Abort beats a simultaneous start in IDLE.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checkOutput("abort_beats_start", {30'd0, busy, mem_en}, 32'd0);
    @(negedge clk);
    checkOutput("abort_beats_start_hold", {28'd0, busy, mem_en, inst_w}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      make_sched_table(vecs[v].al, vecs[v].lat);
      run_pass(vecs[v].kb, vecs[v].ab, vecs[v].al, vecs[v].md, -1, 1'b0,
               d_done, d_nen, d_nk, d_nx, d_fk, d_lk, d_fx, d_lx);
      checkOutput($sformatf("vec%0d_done_cycle", v), d_done, vecs[v].exp_done);
      checkOutput($sformatf("vec%0d_read_count", v), d_nen, COL + vecs[v].al);
      checkOutput($sformatf("vec%0d_kload_insts", v), d_nk, COL);
      checkOutput($sformatf("vec%0d_exec_insts", v), d_nx, vecs[v].al);
      checkOutput($sformatf("vec%0d_first_kaddr", v), d_fk, vecs[v].exp_fk);
      checkOutput($sformatf("vec%0d_last_kaddr", v), d_lk, vecs[v].exp_lk);
      checkOutput($sformatf("vec%0d_first_xaddr", v), d_fx, vecs[v].exp_fx);
      checkOutput($sformatf("vec%0d_last_xaddr", v), d_lx, vecs[v].exp_lx);
    end

    // Abort in the third EXEC cycle, then restart in the very next cycle.
    make_sched_table(6, 2);
    run_pass('h040, 'h300, 6, 1'b1, E0 + 2, 1'b0, d_done, d_nen, d_nk, d_nx, d_fk, d_lk, d_fx, d_lx);
    checkOutput("abort_exec_reads", d_nen, COL + 3);
    make_sched_table(2, 1);
    run_pass('h050, 'h310, 2, 1'b0, -1, 1'b0, d_done, d_nen, d_nk, d_nx, d_fk, d_lk, d_fx, d_lx);
    checkOutput("restart_after_abort_done", d_done, E0 + 3);

    // Start pulses and mode_in toggling while busy must not disturb the pass.
    make_sched_table(5, 3);
    run_pass('h111, 'h222, 5, 1'b1, -1, 1'b1, d_done, d_nen, d_nk, d_nx, d_fk, d_lk, d_fx, d_lx);
    checkOutput("busy_start_done_cycle", d_done, E0 + 3 + 5);

    // Reset mid-pass, then start in the first cycle after release.
    make_sched_table(0, 0);
    @(negedge clk);
    start = 1'b1; kbase = 'h123; abase = 'h456; alen = 5; mode_in = 1'b1;
    repeat (10) begin @(negedge clk); start = 1'b0; end
    checkOutput("midreset_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_outputs", {15'd0, mem_en, mem_addr, inst_w, busy, done, mode}, 32'd0);
    reset = 1'b1; start = 1'b1; kbase = 'h0AA; mode_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("midreset_restart", {19'd0, busy, mem_en, mem_addr}, {19'd0, 1'b1, 1'b1, 11'h0AA});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("midreset_abort_idle", {30'd0, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    carry_inst = 2'b00;

    for (int i = 0; i < 40; i++) begin
      al = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      md = 1'($urandom_range(0, 1));
      make_sched_rand(al);
      m_alen = al;
      ab_cyc = -1;
      if ($urandom_range(0, 4) == 0) ab_cyc = int'($urandom_range(1, model_done()));
      run_pass(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), al, md, ab_cyc, 1'b1,
               d_done, d_nen, d_nk, d_nx, d_fk, d_lk, d_fx, d_lx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter COL, default 8: MAC columns per row; kernel words loaded per pass.
REQ-002 SHALL have parameter ADDR_BW, default 11: memory address width.
REQ-003 SHALL have parameter LEN_BW, default 8: activation-vector count width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a pass.
REQ-007 SHALL have port abort, input, 1: terminate the current pass.
REQ-008 SHALL have port mode_in, input, 1: 0 = 4b act/4b weight, 1 = 2b act/4b weight.
REQ-009 SHALL have port kbase, input, ADDR_BW: kernel start address.
REQ-010 SHALL have port abase, input, ADDR_BW: activation start address.
REQ-011 SHALL have port alen, input, LEN_BW: number of activation vectors.
REQ-012 SHALL have port valid_last, input, 1: valid bit of the array's last column.
REQ-013 SHALL have port mem_en, output, 1: memory read enable.
REQ-014 SHALL have port mem_addr, output, ADDR_BW: memory read address.
REQ-015 SHALL have port inst_w, output, 2: array instruction; bit0 = kernel load, bit1 = execute.
REQ-016 SHALL have port mode, output, 1: latched mode to the array.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-019 SHALL implement states IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE.
REQ-020 In IDLE, start=1 SHALL latch mode_in, kbase, abase and alen, then enter KLOAD.
REQ-021 Start SHALL be ignored in every state other than IDLE.
REQ-022 KLOAD SHALL last exactly COL cycles, with mem_en=1 and mem_addr=kbase+k for k=0..COL-1, then enter KGAP.
REQ-023 KGAP SHALL last exactly COL+1 cycles, with mem_en=0 and issued instruction 00, so the last kernel word settles.
REQ-024 When latched alen=0, KGAP SHALL exit directly to DONE; otherwise it SHALL exit to EXEC.
REQ-025 EXEC SHALL last exactly alen cycles, with mem_en=1 and mem_addr=abase+a for a=0..alen-1, then enter DRAIN.
REQ-026 inst_w SHALL be the issued instruction delayed by one register stage (01 in KLOAD, 10 in EXEC, 00 otherwise), to match the one-cycle memory read latency.
REQ-027 A valid-output counter SHALL clear on entry to EXEC and increment on every cycle with valid_last=1 while in EXEC or DRAIN.
REQ-028 DRAIN SHALL exit to DONE in the cycle after the counter reaches alen.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_BW; base+offset wraps silently.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with mem_en=0 and issued instruction 00 from that edge, and done SHALL stay 0.
REQ-032 abort SHALL win over a simultaneous start in IDLE, and no pass SHALL begin.
REQ-033 mode SHALL be held constant from start until the return to IDLE.

Reset
REQ-034 While reset=0 at a clock edge: state=IDLE; mem_en, mem_addr, inst_w, mode, busy and done=0; all counters=0.
REQ-035 Reset asserted mid-pass SHALL abandon the pass with no done pulse, and the first cycle after release SHALL accept start.

Structure
REQ-036 Shared package mac_ctrl_pkg SHALL hold the state enum, INST_IDLE=2'b00, INST_KLOAD=2'b01 and INST_EXEC=2'b10.
REQ-037 One sub-module, mac_seq_cnt (loadable up-counter with terminal-count flag), SHALL be instantiated for the phase counter and the valid counter.

Verification
REQ-038 Reset with reset=0 for 3 cycles -> all outputs 0, busy=0.
REQ-039 start with kbase=0x010, abase=0x100, alen=4, COL=8 -> mem_addr 0x010..0x017 (8 cycles); inst_w=01 one cycle later for 8 cycles; 9 idle cycles; mem_addr 0x100..0x103; inst_w=10 for 4 cycles; 4 valid_last pulses; done one cycle after the 4th.
REQ-040 alen=0 -> KLOAD and KGAP occur, no EXEC reads, done 1+COL+COL+1 cycles after start.
REQ-041 abase=0x7FE, alen=4, ADDR_BW=11 -> EXEC addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-042 abort in the 3rd EXEC cycle -> next cycle mem_en=0, busy=0; inst_w=00 one cycle later; no done; a new start is accepted next cycle.
REQ-043 start pulsed while busy, plus mode_in toggled mid-pass -> no restart, mode unchanged until done.
